// File: rtl/img2col_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | img2col_pkg : shared types and default geometry for img2col fetch  |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
package img2col_pkg;

  localparam int DEF_IMG_W  = 32;
  localparam int DEF_IMG_H  = 32;
  localparam int DEF_K      = 5;
  localparam int DEF_NUM_PU = DEF_IMG_W - DEF_K + 1;

  typedef enum logic {
    PH_BUF  = 1'b0,
    PH_WORK = 1'b1
  } phase_e;

  typedef struct packed {
    logic       valid;
    logic       done;
    logic [5:0] id;
    logic [2:0] row;
    logic [2:0] slot;
  } fetch_meta_t;

endpackage
`default_nettype wire

// File: rtl/img2col_fetch_meta_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | img2col_meta_pipe : fixed-depth delay line carrying write metadata |
// | Revision          : 1.0                                            |
// +--------------------------------------------------------------------+
module img2col_meta_pipe
  import img2col_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        clr_n,
  input  fetch_meta_t in_meta,
  output fetch_meta_t out_meta
);

  fetch_meta_t stage_q [DEPTH];
  fetch_meta_t stage_d [DEPTH];

  always_comb begin
    stage_d[0] = in_meta;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign out_meta = stage_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/img2col_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | img2col_fetch : maps controller counters to SRAM reads and PU      |
// |                 line-buffer writes                                 |
// | Revision      : 1.0                                                |
// +--------------------------------------------------------------------+
module img2col_fetch
  import img2col_pkg::*;
#(
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int K      = DEF_K,
  parameter int NUM_PU = DEF_NUM_PU,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              map_valid,
  input  logic              map_phase,
  input  logic              map_done,
  input  logic [5:0]        map_round,
  input  logic [5:0]        map_pu1_add,
  input  logic [5:0]        map_pu_no,
  input  logic [5:0]        map_row_no,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              pu_wr_en,
  output logic [5:0]        pu_wr_id,
  output logic [2:0]        pu_wr_row,
  output logic [2:0]        pu_wr_slot,
  output logic [DATA_W-1:0] pu_wr_data,
  output logic              fetch_done,
  output logic              range_err
);

  localparam int         AW1    = ADDR_W + 1;
  localparam logic [6:0] IMG_W7 = 7'(IMG_W);
  localparam logic [6:0] IMG_H7 = 7'(IMG_H);
  localparam logic [6:0] K7     = 7'(K);

  if (NUM_PU != IMG_W - K + 1 || RD_LAT < 1 || RD_LAT > 3 || K > 8) begin : g_cfg_check
    $error("img2col_fetch: inconsistent geometry or RD_LAT out of range");
  end

  phase_e          phase;
  logic [6:0]      col;
  logic [6:0]      src_row;
  logic [6:0]      work_slot;
  logic [AW1-1:0]  addr_full;
  logic            bad_col;
  logic            bad_row;
  logic            in_img;
  logic            accept;
  logic            err_hit;
  fetch_meta_t     meta_in;
  fetch_meta_t     meta_out;
  logic            unused_bits;

  logic              mem_rd_en_d,   mem_rd_en_q;
  logic [ADDR_W-1:0] mem_rd_addr_d, mem_rd_addr_q;
  logic              pu_wr_en_d,    pu_wr_en_q;
  logic [5:0]        pu_wr_id_d,    pu_wr_id_q;
  logic [2:0]        pu_wr_row_d,   pu_wr_row_q;
  logic [2:0]        pu_wr_slot_d,  pu_wr_slot_q;
  logic [DATA_W-1:0] pu_wr_data_d,  pu_wr_data_q;
  logic              fetch_done_d,  fetch_done_q;
  logic              range_err_d,   range_err_q;

  always_comb begin
    phase     = phase_e'(map_phase);
    col       = 7'(map_pu_no) + 7'(map_pu1_add);
    // Working rounds overwrite the oldest row slot in a ring of K rows.
    work_slot = (7'(map_round) + K7) % K7;
    src_row   = (phase == PH_WORK) ? (7'(map_round) + K7) : 7'(map_row_no);
    addr_full = AW1'(src_row) * AW1'(IMG_W) + AW1'(col);

    bad_col = (col >= IMG_W7);
    bad_row = (phase == PH_BUF) && (map_row_no >= 6'(K));
    in_img  = (src_row < IMG_H7);
    err_hit = map_valid && (bad_col || bad_row);
    accept  = map_valid && !bad_col && !bad_row && in_img;

    meta_in       = '0;
    meta_in.valid = accept;
    meta_in.done  = map_done;
    meta_in.id    = map_pu_no;
    meta_in.row   = (phase == PH_WORK) ? work_slot[2:0] : map_row_no[2:0];
    meta_in.slot  = map_pu1_add[2:0];
  end

  assign unused_bits = ^{addr_full[ADDR_W], work_slot[6:3]};

  img2col_meta_pipe #(
    .DEPTH (RD_LAT + 1)
  ) u_meta_pipe (
    .clk      (clk),
    .clr_n    (nrst),
    .in_meta  (meta_in),
    .out_meta (meta_out)
  );

  always_comb begin
    mem_rd_en_d   = accept;
    mem_rd_addr_d = accept ? addr_full[ADDR_W-1:0] : '0;
    range_err_d   = range_err_q | err_hit;
    // Idle cycles present zeros so stale SRAM data never leaks onto the bus.
    pu_wr_en_d    = meta_out.valid;
    pu_wr_id_d    = meta_out.valid ? meta_out.id   : '0;
    pu_wr_row_d   = meta_out.valid ? meta_out.row  : '0;
    pu_wr_slot_d  = meta_out.valid ? meta_out.slot : '0;
    pu_wr_data_d  = meta_out.valid ? mem_rd_data   : '0;
    fetch_done_d  = meta_out.done;
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      mem_rd_en_q   <= 1'b0;
      mem_rd_addr_q <= '0;
      pu_wr_en_q    <= 1'b0;
      pu_wr_id_q    <= '0;
      pu_wr_row_q   <= '0;
      pu_wr_slot_q  <= '0;
      pu_wr_data_q  <= '0;
      fetch_done_q  <= 1'b0;
      range_err_q   <= 1'b0;
    end else begin
      mem_rd_en_q   <= mem_rd_en_d;
      mem_rd_addr_q <= mem_rd_addr_d;
      pu_wr_en_q    <= pu_wr_en_d;
      pu_wr_id_q    <= pu_wr_id_d;
      pu_wr_row_q   <= pu_wr_row_d;
      pu_wr_slot_q  <= pu_wr_slot_d;
      pu_wr_data_q  <= pu_wr_data_d;
      fetch_done_q  <= fetch_done_d;
      range_err_q   <= range_err_d;
    end
  end

  assign mem_rd_en   = mem_rd_en_q;
  assign mem_rd_addr = mem_rd_addr_q;
  assign pu_wr_en    = pu_wr_en_q;
  assign pu_wr_id    = pu_wr_id_q;
  assign pu_wr_row   = pu_wr_row_q;
  assign pu_wr_slot  = pu_wr_slot_q;
  assign pu_wr_data  = pu_wr_data_q;
  assign fetch_done  = fetch_done_q;
  assign range_err   = range_err_q;

endmodule
`default_nettype wire

// File: tb/tb_img2col_fetch.sv
`default_nettype none
// Scoreboard bench: one DUT at RD_LAT=1 and one at RD_LAT=3 share the same stimulus.
module tb_img2col_fetch;

  localparam int W  = 32;
  localparam int H  = 32;
  localparam int KK = 5;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       map_valid = 1'b0;
  logic       map_phase = 1'b0;
  logic       map_done = 1'b0;
  logic [5:0] map_round = '0;
  logic [5:0] map_pu1_add = '0;
  logic [5:0] map_pu_no = '0;
  logic [5:0] map_row_no = '0;

  int errors = 0;
  int checks = 0;
  bit zero_chk = 0;
  bit end_chk = 0;
  bit cnt_clr = 0;
  bit cnt_chk = 0;

  always #5 clk = ~clk;

  typedef struct { longint t; int addr; } rd_exp_t;
  typedef struct { longint t; bit wr; bit done; int id; int row; int slot; int data; } wr_exp_t;
  typedef struct { bit err; bit acc; int addr; int row; } mdl_t;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] mem_f(input int a);
    return 8'((a * 7 + 3) & 255);
  endfunction

  function automatic mdl_t model(input bit v, input bit ph, input int rnd, input int add,
                                 input int pu, input int row);
    mdl_t m;
    int   col;
    int   src;
    col = pu + add;
    if (ph) begin
      src   = rnd + KK;
      m.row = rnd % KK;
    end else begin
      src   = row;
      m.row = row;
    end
    m.err  = v && (col >= W || (!ph && row >= KK));
    m.acc  = v && !m.err && (src < H);
    m.addr = (src * W + col) % 1024;
    return m;
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int L = (gi == 0) ? 1 : 3;

    logic       rd_en;
    logic [9:0] rd_addr;
    logic [7:0] rd_data;
    logic       wr_en;
    logic [5:0] wr_id;
    logic [2:0] wr_row;
    logic [2:0] wr_slot;
    logic [7:0] wr_data;
    logic       done;
    logic       rerr;
    logic [7:0] mq [L];
    rd_exp_t    rq [$];
    wr_exp_t    wq [$];
    bit         err_exp = 0;
    int         wr_cnt = 0;

    img2col_fetch #(
      .IMG_W(32), .IMG_H(32), .K(5), .NUM_PU(28), .DATA_W(8), .ADDR_W(10), .RD_LAT(L)
    ) u_dut (
      .clk(clk), .nrst(nrst),
      .map_valid(map_valid), .map_phase(map_phase), .map_done(map_done),
      .map_round(map_round), .map_pu1_add(map_pu1_add), .map_pu_no(map_pu_no),
      .map_row_no(map_row_no),
      .mem_rd_en(rd_en), .mem_rd_addr(rd_addr), .mem_rd_data(rd_data),
      .pu_wr_en(wr_en), .pu_wr_id(wr_id), .pu_wr_row(wr_row), .pu_wr_slot(wr_slot),
      .pu_wr_data(wr_data), .fetch_done(done), .range_err(rerr)
    );

    // SRAM model with L cycles of read latency
    always @(posedge clk) begin
      mq[0] <= rd_en ? mem_f(int'(rd_addr)) : 8'h00;
      for (int i = 1; i < L; i++) mq[i] <= mq[i-1];
    end
    assign rd_data = mq[L-1];

    always @(posedge clk) begin : p_push
      mdl_t m;
      m = model(map_valid, map_phase, int'(map_round), int'(map_pu1_add),
                int'(map_pu_no), int'(map_row_no));
      if (!nrst) begin
        rq.delete();
        wq.delete();
        err_exp <= 1'b0;
      end else begin
        if (m.err) err_exp <= 1'b1;
        if (m.acc) rq.push_back('{t: longint'($time) + 5, addr: m.addr});
        if (m.acc || map_done)
          wq.push_back('{t: longint'($time) + 5 + 10 * (L + 1), wr: m.acc, done: map_done,
                         id: int'(map_pu_no), row: m.row, slot: int'(map_pu1_add),
                         data: int'(mem_f(m.addr))});
      end
    end

    always @(negedge clk) begin : p_mon
      longint  now;
      rd_exp_t r;
      wr_exp_t w;
      now = longint'($time);
      chk(rerr == err_exp, $sformatf("L%0d range_err", L), longint'(rerr), longint'(err_exp));

      while (rq.size() > 0 && rq[0].t < now) begin
        chk(1'b0, $sformatf("L%0d missing_read", L), 0, rq[0].addr);
        void'(rq.pop_front());
      end
      if (rd_en) begin
        if (rq.size() == 0) chk(1'b0, $sformatf("L%0d spurious_read", L), longint'(rd_addr), -1);
        else begin
          r = rq.pop_front();
          chk(now == r.t, $sformatf("L%0d rd_time", L), now, r.t);
          chk(int'(rd_addr) == r.addr, $sformatf("L%0d rd_addr", L), longint'(rd_addr), r.addr);
        end
      end

      while (wq.size() > 0 && wq[0].t < now) begin
        chk(1'b0, $sformatf("L%0d missing_write", L), 0, wq[0].t);
        void'(wq.pop_front());
      end
      if (wr_en || done) begin
        if (wq.size() == 0)
          chk(1'b0, $sformatf("L%0d spurious_write", L), longint'({wr_en, done}), 0);
        else begin
          w = wq.pop_front();
          chk(now == w.t, $sformatf("L%0d wr_time", L), now, w.t);
          chk(wr_en == w.wr, $sformatf("L%0d wr_en", L), longint'(wr_en), longint'(w.wr));
          chk(done == w.done, $sformatf("L%0d fetch_done", L), longint'(done), longint'(w.done));
          if (w.wr) begin
            chk(int'(wr_id) == w.id, $sformatf("L%0d wr_id", L), longint'(wr_id), w.id);
            chk(int'(wr_row) == w.row, $sformatf("L%0d wr_row", L), longint'(wr_row), w.row);
            chk(int'(wr_slot) == w.slot, $sformatf("L%0d wr_slot", L), longint'(wr_slot), w.slot);
            chk(int'(wr_data) == w.data, $sformatf("L%0d wr_data", L), longint'(wr_data), w.data);
          end
        end
      end

      if (zero_chk) begin
        chk({rd_en, rd_addr, wr_en, wr_id, wr_row, wr_slot, wr_data, done, rerr} == '0,
            $sformatf("L%0d outputs_zero", L),
            longint'({rd_en, rd_addr, wr_en, wr_id, wr_row, wr_slot, wr_data, done, rerr}), 0);
      end
      if (cnt_clr) wr_cnt = 0;
      if (wr_en) wr_cnt++;
      if (cnt_chk) chk(wr_cnt == 700 + 27 * 15, $sformatf("L%0d sweep_writes", L), wr_cnt, 700 + 27 * 15);
      if (end_chk) begin
        chk(rq.size() == 0, $sformatf("L%0d rd_left", L), rq.size(), 0);
        chk(wq.size() == 0, $sformatf("L%0d wr_left", L), wq.size(), 0);
      end
    end
  end

  task automatic drive(input bit v, input bit ph, input bit dn, input int rnd, input int add,
                       input int pu, input int row);
    @(posedge clk);
    #2;
    map_valid   = v;
    map_phase   = ph;
    map_done    = dn;
    map_round   = 6'(rnd);
    map_pu1_add = 6'(add);
    map_pu_no   = 6'(pu);
    map_row_no  = 6'(row);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic pulse(input bit v, input bit ph, input bit dn, input int rnd, input int add,
                       input int pu, input int row);
    drive(v, ph, dn, rnd, add, pu, row);
    idle(1);
  endtask

  task automatic chk_rd(input bit en, input int addr);
    chk(g_dut[0].rd_en == en, "L1 hand_rd_en", longint'(g_dut[0].rd_en), longint'(en));
    chk(g_dut[1].rd_en == en, "L3 hand_rd_en", longint'(g_dut[1].rd_en), longint'(en));
    if (en) begin
      chk(int'(g_dut[0].rd_addr) == addr, "L1 hand_rd_addr", longint'(g_dut[0].rd_addr), addr);
      chk(int'(g_dut[1].rd_addr) == addr, "L3 hand_rd_addr", longint'(g_dut[1].rd_addr), addr);
    end
  endtask

  task automatic chk_err(input bit e);
    chk(g_dut[0].rerr == e, "L1 hand_range_err", longint'(g_dut[0].rerr), longint'(e));
    chk(g_dut[1].rerr == e, "L3 hand_range_err", longint'(g_dut[1].rerr), longint'(e));
  endtask

  task automatic chk_wr(input int i, input int id, input int row, input int slot, input int data);
    logic       en;
    logic [5:0] wid;
    logic [2:0] wrow;
    logic [2:0] wslot;
    logic [7:0] wdat;
    if (i == 0) begin
      en = g_dut[0].wr_en; wid = g_dut[0].wr_id; wrow = g_dut[0].wr_row;
      wslot = g_dut[0].wr_slot; wdat = g_dut[0].wr_data;
    end else begin
      en = g_dut[1].wr_en; wid = g_dut[1].wr_id; wrow = g_dut[1].wr_row;
      wslot = g_dut[1].wr_slot; wdat = g_dut[1].wr_data;
    end
    chk(en == 1'b1, "hand_wr_en", longint'(en), 1);
    chk({wid, wrow, wslot} == {6'(id), 3'(row), 3'(slot)}, "hand_wr_meta",
        longint'({wid, wrow, wslot}), longint'({6'(id), 3'(row), 3'(slot)}));
    chk(int'(wdat) == data, "hand_wr_data", longint'(wdat), data);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    nrst = 1'b1;
    zero_chk = 1'b1;
    @(posedge clk);
    #2;
    zero_chk = 1'b0;

    // buffering: row 2, PU 3, slot 4 -> addr 71, data mem_f(71)=244
    pulse(1, 0, 0, 0, 4, 3, 2);
    @(negedge clk); chk_rd(1, 71);
    repeat (2) @(negedge clk); chk_wr(0, 3, 2, 4, 244);
    repeat (2) @(negedge clk); chk_wr(1, 3, 2, 4, 244);

    // working round 0, PU 27, slot 4 -> 5*32+31
    pulse(1, 1, 0, 0, 4, 27, 0);
    @(negedge clk); chk_rd(1, 191);
    // working round 3 -> source row 8, row slot 3
    pulse(1, 1, 0, 3, 0, 0, 0);
    @(negedge clk); chk_rd(1, 256);
    // working round 27 -> tail suppressed, no error
    pulse(1, 1, 0, 27, 0, 0, 0);
    @(negedge clk); chk_rd(0, 0); chk_err(0);
    idle(6);

    // lone done token
    pulse(0, 1, 1, 0, 0, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk(g_dut[0].done == (k == 3), "L1 hand_done", longint'(g_dut[0].done), longint'(k == 3));
      chk(g_dut[1].done == (k == 5), "L3 hand_done", longint'(g_dut[1].done), longint'(k == 5));
    end

    // done together with a request
    pulse(1, 0, 1, 0, 1, 1, 1);
    idle(6);

    // column out of image -> sticky error until reset
    pulse(1, 0, 0, 0, 4, 30, 0);
    @(negedge clk); chk_rd(0, 0); chk_err(1);
    idle(3);
    @(negedge clk); chk_err(1);
    @(posedge clk); #2 nrst = 1'b0;
    @(posedge clk); #2 nrst = 1'b1;
    @(negedge clk); chk_err(0);

    // buffering row beyond K
    pulse(1, 0, 0, 0, 0, 0, 5);
    @(negedge clk); chk_rd(0, 0); chk_err(1);

    // reset with two reads in flight
    drive(1, 0, 0, 0, 0, 5, 1);
    drive(1, 0, 0, 0, 0, 6, 1);
    @(posedge clk); #2 map_valid = 1'b0; nrst = 1'b0;
    @(posedge clk); #2 nrst = 1'b1; zero_chk = 1'b1;
    @(posedge clk); #2 zero_chk = 1'b0;
    idle(8);

    // full buffering sweep, then working rounds back-to-back while draining
    @(posedge clk); #2 cnt_clr = 1'b1;
    @(posedge clk); #2 cnt_clr = 1'b0;
    for (int r = 0; r < 5; r++)
      for (int p = 0; p < 28; p++)
        for (int s = 0; s < 5; s++)
          drive(1, 0, (r == 4 && p == 27 && s == 4), 0, s, p, r);
    for (int rnd = 0; rnd < 28; rnd++)
      for (int p = 0; p < 3; p++)
        for (int s = 0; s < 5; s++)
          drive(1, 1, (rnd == 27 && p == 2 && s == 4), rnd, s, p, 0);
    idle(8);
    @(posedge clk); #2 cnt_chk = 1'b1;
    @(posedge clk); #2 cnt_chk = 1'b0; end_chk = 1'b1;
    @(posedge clk); #2 end_chk = 1'b0;
    @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
